// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    localparam int N_IN = 4;
    localparam int TT_W = 16;

    // state  | meaning
    // IDLE   | waiting for start, gate inputs parked at 0
    // APPLY  | holding vector k while the settle timer runs
    // SAMPLE | capturing gate output for vector k
    // DONE   | one-cycle completion, results valid
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_e;

    // Vector 0 lands in the MSB so the table reads like the design-set hex names.
    function automatic logic [N_IN-1:0] tt_bit_pos(input logic [N_IN-1:0] k);
        return N_IN'(TT_W - 1) - k;
    endfunction

    function automatic logic [N_IN-1:0] first_mismatch(input logic [TT_W-1:0] mask);
        logic [N_IN-1:0] idx;
        idx = '0;
        for (int k = TT_W - 1; k >= 0; k--) begin
            if (mask[TT_W - 1 - k]) idx = N_IN'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that reports when it has reached zero.
module tt_settle_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Steps a 4-input gate through all 16 vectors, captures its truth table and
// compares it against an expected word.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [TT_W-1:0] i_exp_tt,
    output logic [N_IN-1:0] o_gate_in,
    input  logic            i_gate_out,
    output logic            o_busy,
    output logic            o_done,
    output logic [TT_W-1:0] o_tt_out,
    output logic            o_pass,
    output logic [TT_W-1:0] o_err_mask,
    output logic [N_IN-1:0] o_first_err
);

    localparam int  TW          = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam bit  ZERO_SETTLE = (SETTLE_CYCLES == 0);
    // APPLY spends RELOAD+1 cycles; SAMPLE supplies the final cycle of the hold.
    localparam logic [TW-1:0] RELOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    sweep_state_e    r_state;
    sweep_state_e    w_state_nxt;
    logic [N_IN-1:0] r_k;
    logic [TT_W-1:0] r_exp_tt;
    logic [TT_W-1:0] r_tt_out;
    logic [TT_W-1:0] r_err_mask;
    logic [N_IN-1:0] r_first_err;
    logic            r_pass;
    logic [TT_W-1:0] w_tt_nxt;
    logic            w_accept;
    logic            w_sample_wr;
    logic            w_last;
    logic            w_tmr_load;
    logic            w_tmr_zero;

    assign w_last     = (r_k == N_IN'(TT_W - 1));
    assign w_tmr_load = (w_state_nxt == ST_APPLY) && (r_state != ST_APPLY);

    tt_settle_timer #(.W(TW)) u_settle (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (RELOAD),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample_wr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ZERO_SETTLE ? ST_SAMPLE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (i_abort)         w_state_nxt = ST_IDLE;
                else if (w_tmr_zero) w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sample_wr = 1'b1;
                    if (w_last) w_state_nxt = ST_DONE;
                    else        w_state_nxt = ZERO_SETTLE ? ST_SAMPLE : ST_APPLY;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tt_nxt = r_tt_out;
        w_tt_nxt[tt_bit_pos(r_k)] = i_gate_out;
    end

    // r_k doubles as the registered gate drive; it wraps to 0 after vector 15.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k         <= '0;
            r_exp_tt    <= '0;
            r_tt_out    <= '0;
            r_err_mask  <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
        end else if (w_accept) begin
            r_k         <= '0;
            r_exp_tt    <= i_exp_tt;
            r_tt_out    <= '0;
            r_err_mask  <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
        end else if (w_sample_wr) begin
            r_tt_out <= w_tt_nxt;
            r_k      <= r_k + N_IN'(1);
            if (w_last) begin
                r_err_mask  <= w_tt_nxt ^ r_exp_tt;
                r_pass      <= (w_tt_nxt == r_exp_tt);
                r_first_err <= first_mismatch(w_tt_nxt ^ r_exp_tt);
            end
        end else if (w_state_nxt == ST_IDLE) begin
            r_k <= '0;
        end
    end

    assign o_gate_in   = r_k;
    assign o_busy      = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_tt_out    = r_tt_out;
    assign o_pass      = r_pass;
    assign o_err_mask  = r_err_mask;
    assign o_first_err = r_first_err;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: one instance with settle 2, one with settle 0,
// each driving a truth-table gate model held in the bench.
module tb_tt_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start[2], abort[2], gate_out[2], busy[2], done[2], pass[2];
    logic [15:0] exp_tt[2], tt_out[2], err_mask[2], gate_tt[2];
    logic [3:0]  gate_in[2], first_err[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tt_sweep_ctrl #(.SETTLE_CYCLES((g == 0) ? 2 : 0)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_start     (start[g]),
            .i_abort     (abort[g]),
            .i_exp_tt    (exp_tt[g]),
            .o_gate_in   (gate_in[g]),
            .i_gate_out  (gate_out[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_tt_out    (tt_out[g]),
            .o_pass      (pass[g]),
            .o_err_mask  (err_mask[g]),
            .o_first_err (first_err[g])
        );
        assign gate_out[g] = gate_tt[g][4'd15 - gate_in[g]];
    end

    typedef struct {
        logic [15:0] tt;
        logic        pass;
        logic [15:0] err;
        logic [3:0]  first;
        int          done_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    endtask

    task automatic fail_now(string name);
        n_chk++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    function automatic int settle(int g);
        return (g == 0) ? 2 : 0;
    endfunction

    function automatic logic f_ref(logic [3:0] k);
        logic a0, a1, a2, a3;
        {a0, a1, a2, a3} = k;
        return ~((~a0 & a1 & ~a2) | (a0 & ~a1 & a2 & ~a3) | (a3 & ~(a0 & ~a1)));
    endfunction

    function automatic logic [15:0] table_of_f();
        logic [15:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[15 - k] = f_ref(4'(k));
        return t;
    endfunction

    // Expected result of a full sweep: measured bit for vector k is the gate's
    // response to k; mismatches are found by walking k upward.
    function automatic exp_t predict(logic [15:0] g_tt, logic [15:0] x, int g, int e0);
        exp_t e;
        e.tt = '0;
        for (int k = 0; k < 16; k++) e.tt[15 - k] = g_tt[15 - k];
        e.err   = e.tt ^ x;
        e.pass  = (e.tt == x);
        e.first = '0;
        for (int k = 15; k >= 0; k--) if (e.err[15 - k]) e.first = 4'(k);
        e.done_cyc = e0 + 16 * (settle(g) + 1);
        return e;
    endfunction

    function automatic int qsize(int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (done[g] === 1'b1) begin
                if (qsize(g) == 0) begin
                    fail_now($sformatf("unexpected_done_%0d", g));
                end else begin
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("tt_out_%0d", g),    tt_out[g],    e.tt);
                    check($sformatf("pass_%0d", g),      pass[g],      e.pass);
                    check($sformatf("err_mask_%0d", g),  err_mask[g],  e.err);
                    check($sformatf("first_err_%0d", g), first_err[g], e.first);
                    check($sformatf("done_cycle_%0d", g), cyc,         e.done_cyc);
                    check($sformatf("busy_at_done_%0d", g), busy[g],   1'b0);
                end
            end
        end
    end

    task automatic launch(int g, logic [15:0] g_tt, logic [15:0] x, bit push_it);
        @(negedge clk);
        gate_tt[g] = g_tt;
        exp_tt[g]  = x;
        start[g]   = 1'b1;
        if (push_it) begin
            if (g == 0) q0.push_back(predict(g_tt, x, g, cyc + 1));
            else        q1.push_back(predict(g_tt, x, g, cyc + 1));
        end
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_idle(int g);
        int n = 0;
        while (qsize(g) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (qsize(g) != 0) begin
            fail_now($sformatf("done_timeout_%0d", g));
            if (g == 0) q0.delete();
            else        q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset(int g, string tag);
        check({tag, "_gate_in"},   gate_in[g],   4'h0);
        check({tag, "_busy"},      busy[g],      1'b0);
        check({tag, "_done"},      done[g],      1'b0);
        check({tag, "_tt_out"},    tt_out[g],    16'h0);
        check({tag, "_pass"},      pass[g],      1'b0);
        check({tag, "_err_mask"},  err_mask[g],  16'h0);
        check({tag, "_first_err"}, first_err[g], 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] g_tt, x, f_tt;
        int bad, bad_busy, e0, n, g;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; exp_tt[i] = '0; gate_tt[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset(0, "reset0");
        check_reset(1, "reset1");

        // Reference gate, matching expectation, vector sequence and hold time.
        f_tt = table_of_f();
        check("ref_model_table", f_tt, 16'hA2DA);
        launch(0, f_tt, 16'hA2DA, 1);
        e0 = cyc;
        bad = 0; bad_busy = 0;
        for (int j = 0; j < 48; j++) begin
            if (gate_in[0] !== 4'(j / 3)) bad++;
            if (busy[0] !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        check("gate_in_sequence", bad, 0);
        check("busy_during_sweep", bad_busy, 0);
        wait_idle(0);

        // Expectation off by the last vector.
        launch(0, f_tt, 16'hA2DB, 1);
        wait_idle(0);

        // Gate tied high on the zero-settle instance.
        launch(1, 16'hFFFF, 16'h0000, 1);
        wait_idle(1);

        // Abort during the seventh vector's sample cycle.
        g_tt = 16'($urandom) | 16'hFC00;
        launch(0, g_tt, 16'($urandom), 0);
        e0 = cyc;
        while (cyc < e0 + 20) @(negedge clk);
        check("busy_before_abort", busy[0], 1'b1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("busy_after_abort", busy[0], 1'b0);
        check("gate_in_after_abort", gate_in[0], 4'h0);
        check("tt_partial_after_abort", tt_out[0], g_tt & 16'hFC00);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || gate_in[0] !== 4'h0) bad++;
        end
        check("idle_after_abort", bad, 0);

        // Start hammered mid-sweep and in the DONE cycle, then a real restart.
        g_tt = 16'($urandom);
        launch(0, g_tt, g_tt ^ 16'h0100, 1);
        n = 0;
        while (done[0] !== 1'b1 && n < 200) begin
            start[0]  = 1'($urandom);
            exp_tt[0] = 16'($urandom);
            @(negedge clk);
            n++;
        end
        if (done[0] !== 1'b1) fail_now("done_timeout_restart");
        start[0] = 1'b1;
        @(negedge clk);
        g_tt = 16'($urandom);
        x    = 16'($urandom);
        gate_tt[0] = g_tt;
        exp_tt[0]  = x;
        q0.push_back(predict(g_tt, x, 0, cyc + 1));
        @(negedge clk);
        start[0] = 1'b0;
        check("restart_busy", busy[0], 1'b1);
        check("restart_tt_cleared", tt_out[0], 16'h0);
        check("restart_err_cleared", err_mask[0], 16'h0);
        check("restart_first_cleared", first_err[0], 4'h0);
        wait_idle(0);

        // Randomized sweeps on both instances.
        for (int i = 0; i < 10; i++) begin
            g    = int'($urandom_range(1, 0));
            g_tt = 16'($urandom);
            case ($urandom_range(2, 0))
                0:       x = g_tt;
                1:       x = g_tt ^ (16'h1 << $urandom_range(15, 0));
                default: x = 16'($urandom);
            endcase
            launch(g, g_tt, x, 1);
            wait_idle(g);
        end

        // Reset mid-sweep with start held, after results have been populated.
        g_tt = 16'($urandom) | 16'hF000;
        launch(0, g_tt, 16'($urandom), 0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        start[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_reset(0, "rst_held0");
        rst = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        check_reset(0, "rst_mid0");
        check_reset(1, "rst_mid1");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
        end
        check("no_sweep_after_rst", bad, 0);

        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
